// File: rtl/twi_status_capture_pkg.sv
// Shared TWI status-stage constants: status code width, the idle code,
// TWSR bit positions and the status/interrupt FSM state encoding.
package twi_status_capture_pkg;

    localparam int unsigned TWS_WIDTH = 5;
    localparam logic [TWS_WIDTH-1:0] TWS_IDLE_CODE = 5'h1F;

    // TWSR read view bit positions
    localparam int unsigned TWINT_BIT = 5;
    localparam int unsigned IE_BIT    = 6;
    localparam int unsigned OVR_BIT   = 7;

    // Control write bit positions
    localparam int unsigned WR_TWINT_CLR = 0;
    localparam int unsigned WR_IE        = 1;
    localparam int unsigned WR_OVR_CLR   = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        RELEASE = 2'd2
    } tws_state_e;

endpackage

// File: rtl/twi_status_capture.sv
// Registered TWI status/interrupt stage: latches the status code on each
// completion strobe, holds the bus stalled until software clears TWINT.
module twi_status_capture
    import twi_status_capture_pkg::*;
(
    input  logic                 pclk,
    input  logic                 presetn,
    input  logic [TWS_WIDTH-1:0] status_value,
    input  logic                 status_valid,
    input  logic                 stop_done,
    input  logic                 reg_wr_en,
    input  logic [7:0]           reg_wdata,
    output logic [7:0]           tws_rdata,
    output logic                 twint,
    output logic                 irq,
    output logic                 bus_stall,
    output logic                 resume
);

    tws_state_e           state, state_nxt;
    logic [TWS_WIDTH-1:0] status, status_nxt;
    logic                 ie, ie_nxt;
    logic                 ovr, ovr_nxt;
    logic                 twint_clr;
    logic                 ovr_clr;
    logic                 wdata_unused;

    assign twint_clr    = reg_wr_en & reg_wdata[WR_TWINT_CLR];
    assign ovr_clr      = reg_wr_en & reg_wdata[WR_OVR_CLR];
    assign wdata_unused = ^reg_wdata[7:3];

    always_comb begin
        state_nxt  = state;
        status_nxt = status;
        ie_nxt     = reg_wr_en ? reg_wdata[WR_IE] : ie;
        ovr_nxt    = ovr & ~ovr_clr;

        unique case (state)
            IDLE: begin
                if (status_valid) begin
                    status_nxt = status_value;
                    state_nxt  = PENDING;
                end else if (stop_done) begin
                    status_nxt = TWS_IDLE_CODE;
                end
            end
            PENDING: begin
                // Any event while unacknowledged is dropped and flagged,
                // including one coincident with the clearing write.
                if (status_valid) begin
                    ovr_nxt = 1'b1;
                end
                if (twint_clr) begin
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                if (status_valid) begin
                    status_nxt = status_value;
                    state_nxt  = PENDING;
                end else begin
                    if (stop_done) begin
                        status_nxt = TWS_IDLE_CODE;
                    end
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state  <= IDLE;
            status <= TWS_IDLE_CODE;
            ie     <= 1'b0;
            ovr    <= 1'b0;
        end else begin
            state  <= state_nxt;
            status <= status_nxt;
            ie     <= ie_nxt;
            ovr    <= ovr_nxt;
        end
    end

    assign twint     = (state == PENDING);
    assign bus_stall = (state == PENDING);
    assign resume    = (state == RELEASE);
    assign irq       = twint & ie;

    always_comb begin
        tws_rdata                  = '0;
        tws_rdata[TWS_WIDTH-1:0]   = status;
        tws_rdata[TWINT_BIT]       = twint;
        tws_rdata[IE_BIT]          = ie;
        tws_rdata[OVR_BIT]         = ovr;
    end

endmodule

// File: tb/tb_twi_status_capture.sv
// Scoreboard bench for twi_status_capture: each stimulus cycle pushes its
// expected post-edge outputs, which are popped and compared after the edge.
module tb_twi_status_capture;

    logic       pclk = 1'b0;
    logic       presetn;
    logic [4:0] status_value;
    logic       status_valid;
    logic       stop_done;
    logic       reg_wr_en;
    logic [7:0] reg_wdata;
    logic [7:0] tws_rdata;
    logic       twint;
    logic       irq;
    logic       bus_stall;
    logic       resume;

    typedef struct packed {
        logic [7:0] rdata;
        logic       irq;
        logic       stall;
        logic       resume;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    twi_status_capture dut (
        .pclk         (pclk),
        .presetn      (presetn),
        .status_value (status_value),
        .status_valid (status_valid),
        .stop_done    (stop_done),
        .reg_wr_en    (reg_wr_en),
        .reg_wdata    (reg_wdata),
        .tws_rdata    (tws_rdata),
        .twint        (twint),
        .irq          (irq),
        .bus_stall    (bus_stall),
        .resume       (resume)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, want);
        end
    endtask

    // Drive one cycle of inputs, push the expected post-edge outputs, then
    // pop and compare them #1 after the edge.
    task automatic cyc(input string name, input logic rst_n, input logic sv,
                       input logic [4:0] val, input logic stop, input logic wr,
                       input logic [7:0] wd, input logic [7:0] e_rd,
                       input logic e_irq, input logic e_stall, input logic e_res);
        exp_t e;
        presetn      = rst_n;
        status_valid = sv;
        status_value = val;
        stop_done    = stop;
        reg_wr_en    = wr;
        reg_wdata    = wd;
        exp_q.push_back('{rdata: e_rd, irq: e_irq, stall: e_stall, resume: e_res});
        @(posedge pclk);
        #1;
        e = exp_q.pop_front();
        check({name, ".rdata"},  tws_rdata,        e.rdata);
        check({name, ".twint"},  {7'd0, twint},    {7'd0, e.rdata[5]});
        check({name, ".irq"},    {7'd0, irq},      {7'd0, e.irq});
        check({name, ".stall"},  {7'd0, bus_stall}, {7'd0, e.stall});
        check({name, ".resume"}, {7'd0, resume},   {7'd0, e.resume});
    endtask

    initial begin
        presetn = 1'b0; status_valid = 1'b0; status_value = '0;
        stop_done = 1'b0; reg_wr_en = 1'b0; reg_wdata = '0;
        #2;
        //   name          rst sv  val    stp wr  wdata  rdata  irq st res
        cyc("reset",       0,  0, 5'h00, 0,  0, 8'h00, 8'h1F, 0, 0, 0);
        cyc("idle",        1,  0, 5'h00, 0,  0, 8'h00, 8'h1F, 0, 0, 0);
        cyc("ie_set",      1,  0, 5'h00, 0,  1, 8'h02, 8'h5F, 0, 0, 0);
        cyc("cap01",       1,  1, 5'h01, 0,  0, 8'h00, 8'h61, 1, 1, 0);
        cyc("hold",        1,  0, 5'h00, 0,  0, 8'h00, 8'h61, 1, 1, 0);
        cyc("clr03",       1,  0, 5'h00, 0,  1, 8'h03, 8'h41, 0, 0, 1);
        cyc("resume_end",  1,  0, 5'h00, 0,  0, 8'h00, 8'h41, 0, 0, 0);
        cyc("cap03",       1,  1, 5'h03, 0,  0, 8'h00, 8'h63, 1, 1, 0);
        cyc("ovr05",       1,  1, 5'h05, 0,  0, 8'h00, 8'hE3, 1, 1, 0);
        cyc("stop_pend",   1,  0, 5'h00, 1,  0, 8'h00, 8'hE3, 1, 1, 0);
        cyc("ovr_clr",     1,  0, 5'h00, 0,  1, 8'h06, 8'h63, 1, 1, 0);
        cyc("ie_off",      1,  0, 5'h00, 0,  1, 8'h00, 8'h23, 0, 1, 0);
        cyc("clr_ie",      1,  0, 5'h00, 0,  1, 8'h03, 8'h43, 0, 0, 1);
        cyc("rel_cap07",   1,  1, 5'h07, 0,  0, 8'h00, 8'h67, 1, 1, 0);
        cyc("clr_vs_ev",   1,  1, 5'h09, 0,  1, 8'h07, 8'hC7, 0, 0, 1);
        cyc("ovr_clr2",    1,  0, 5'h00, 0,  1, 8'h04, 8'h07, 0, 0, 0);
        cyc("clr_idle",    1,  0, 5'h00, 0,  1, 8'h01, 8'h07, 0, 0, 0);
        cyc("stop_idle",   1,  0, 5'h00, 1,  0, 8'h00, 8'h1F, 0, 0, 0);
        cyc("sv_vs_stop",  1,  1, 5'h0A, 1,  0, 8'h00, 8'h2A, 0, 1, 0);
        cyc("ie_late",     1,  0, 5'h00, 0,  1, 8'h02, 8'h6A, 1, 1, 0);
        cyc("rst_pend",    0,  0, 5'h00, 0,  0, 8'h00, 8'h1F, 0, 0, 0);
        cyc("post_rst",    1,  0, 5'h00, 0,  0, 8'h00, 8'h1F, 0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
